// File: rtl/cu_seq.sv
// cu_seq: multi-cycle MIPS control unit with a built-in phase sequencer.
// Each instruction class visits only the phases it needs. FETCH and MEM stall
// on mem_ready, and a bounded wait counter halts the unit if memory never answers.
// Optional feature macro: CU_TRAP_EN. When it is defined, an unknown instruction
// halts the unit and raises illegal. Otherwise it runs as a 2-cycle NOP.
module cu_seq #(
    parameter int ALUOP_W  = 6,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         irfunc,
    input  logic [4:0]         regimm,
    input  logic               mem_ready,
    output logic [4:0]         phase,
    output logic               ir_we,
    output logic               pc_inc,
    output logic               pc_we,
    output logic               pc_cond_we,
    output logic               mem_req,
    output logic               mem_we,
    output logic [1:0]         lorD,
    output logic               reg_we,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic [1:0]         alu_src_a,
    output logic [2:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_src,
    output logic               instr_done,
`ifdef CU_TRAP_EN
    output logic               illegal,
`endif
    output logic               halted
);

    // State encoding equals the phase output; HALT is the all-zero state.
    localparam logic [4:0] S_HALT   = 5'b00000;
    localparam logic [4:0] S_FETCH  = 5'b00001;
    localparam logic [4:0] S_DECODE = 5'b00010;
    localparam logic [4:0] S_EXEC   = 5'b00100;
    localparam logic [4:0] S_MEM    = 5'b01000;
    localparam logic [4:0] S_WB     = 5'b10000;

    localparam logic [3:0] C_ILL   = 4'd0;
    localparam logic [3:0] C_RCALC = 4'd1;
    localparam logic [3:0] C_ICALC = 4'd2;
    localparam logic [3:0] C_LW    = 4'd3;
    localparam logic [3:0] C_SW    = 4'd4;
    localparam logic [3:0] C_BR    = 4'd5;
    localparam logic [3:0] C_J     = 4'd6;
    localparam logic [3:0] C_JAL   = 4'd7;
    localparam logic [3:0] C_JR    = 4'd8;
    localparam logic [3:0] C_JALR  = 4'd9;

    localparam logic [5:0] A_ADD  = 6'b000010;
    localparam logic [5:0] A_BEQ  = 6'b000110;
    localparam logic [5:0] A_BNE  = 6'b100001;
    localparam logic [5:0] A_BGEZ = 6'b010100;
    localparam logic [5:0] A_BGTZ = 6'b100010;
    localparam logic [5:0] A_BLEZ = 6'b001100;
    localparam logic [5:0] A_BLTZ = 6'b100100;
    localparam logic [5:0] A_SLT  = 6'b001001;
    localparam logic [5:0] A_AND  = 6'b001000;
    localparam logic [5:0] A_OR   = 6'b010000;
    localparam logic [5:0] A_XOR  = 6'b010001;
    localparam logic [5:0] A_NOR  = 6'b100000;
    localparam logic [5:0] A_PASS = 6'b001010;

    logic [4:0]       state, next;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cls;
    logic [5:0]       exec_op;
    logic [2:0]       b_sel;
    logic [5:0]       op6;
    logic             cnt_max;

    assign cnt_max = (cnt == CNT_W'(WAIT_MAX));

    // Classify the instruction and pick its EXEC ALU code and B operand.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        cls     = C_ILL;
        exec_op = 6'b000000;
        b_sel   = 3'b000;
        case (op)
            6'h00: begin
                b_sel = 3'b001;
                case (irfunc)
                    6'h20: begin cls = C_RCALC; exec_op = A_ADD;  end
                    6'h24: begin cls = C_RCALC; exec_op = A_AND;  end
                    6'h25: begin cls = C_RCALC; exec_op = A_OR;   end
                    6'h26: begin cls = C_RCALC; exec_op = A_XOR;  end
                    6'h27: begin cls = C_RCALC; exec_op = A_NOR;  end
                    6'h2A: begin cls = C_RCALC; exec_op = A_SLT;  end
                    6'h08: begin cls = C_JR;    exec_op = A_PASS; b_sel = 3'b000; end
                    6'h09: begin cls = C_JALR;  exec_op = A_PASS; b_sel = 3'b000; end
                    default: ;
                endcase
            end
            6'h01: begin
                b_sel = 3'b010;
                case (regimm)
                    5'h00:   begin cls = C_BR; exec_op = A_BLTZ; end
                    5'h01:   begin cls = C_BR; exec_op = A_BGEZ; end
                    default: ;
                endcase
            end
            6'h02: cls = C_J;
            6'h03: cls = C_JAL;
            6'h04: begin cls = C_BR;    exec_op = A_BEQ;  b_sel = 3'b001; end
            6'h05: begin cls = C_BR;    exec_op = A_BNE;  b_sel = 3'b001; end
            6'h06: begin cls = C_BR;    exec_op = A_BLEZ; b_sel = 3'b010; end
            6'h07: begin cls = C_BR;    exec_op = A_BGTZ; b_sel = 3'b010; end
            6'h09: begin cls = C_ICALC; exec_op = A_ADD;  b_sel = 3'b011; end
            6'h0C: begin cls = C_ICALC; exec_op = A_AND;  b_sel = 3'b100; end
            6'h0D: begin cls = C_ICALC; exec_op = A_OR;   b_sel = 3'b100; end
            6'h0E: begin cls = C_ICALC; exec_op = A_XOR;  b_sel = 3'b100; end
            6'h23: begin cls = C_LW;    exec_op = A_ADD;  b_sel = 3'b011; end
            6'h2B: begin cls = C_SW;    exec_op = A_ADD;  b_sel = 3'b011; end
            default: ;
        endcase
    end

    // Phase sequencing: per-class routing, memory stalls and the timeout halt.
    always_comb begin
        next = state;
        case (state)
            S_FETCH: begin
                if (mem_ready)    next = S_DECODE;
                else if (cnt_max) next = S_HALT;
            end
            S_DECODE: begin
                if (cls == C_ILL)
`ifdef CU_TRAP_EN
                    next = S_HALT;
`else
                    next = S_FETCH;
`endif
                else
                    next = S_EXEC;
            end
            S_EXEC: begin
                case (cls)
                    C_RCALC, C_ICALC, C_JAL, C_JALR: next = S_WB;
                    C_LW, C_SW:                      next = S_MEM;
                    default:                         next = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready)    next = (cls == C_LW) ? S_WB : S_FETCH;
                else if (cnt_max) next = S_HALT;
            end
            S_WB:    next = S_FETCH;
            S_HALT:  next = S_HALT;
            default: next = S_FETCH;
        endcase
    end

    // State and wait-counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
        if (reset) begin
            state <= S_FETCH;
            cnt   <= '0;
        end else begin
            state <= next;
            if (mem_ready || next != state)
                cnt <= '0;
            else if (state == S_FETCH || state == S_MEM)
                cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef CU_TRAP_EN
    logic illegal_q;

    // Sticky illegal-instruction flag, raised when DECODE sees an unknown encoding.
    always_ff @(posedge clk) begin
        if (reset)
            illegal_q <= 1'b0;
        else if (state == S_DECODE && cls == C_ILL)
            illegal_q <= 1'b1;
    end

    assign illegal = illegal_q;
`endif

    // Control strobes and mux selects decoded from phase and instruction class.
    always_comb begin
        ir_we      = 1'b0;
        pc_inc     = 1'b0;
        pc_we      = 1'b0;
        pc_cond_we = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        lorD       = 2'b00;
        reg_we     = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 3'b000;
        op6        = 6'b000000;
        pc_src     = 2'b00;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                lorD    = 2'b01;
                ir_we   = mem_ready;
            end
            S_DECODE: begin
                pc_inc = 1'b1;
                if (cls == C_BR) begin
                    alu_src_a = 2'b01;
                    alu_src_b = 3'b101;
                    op6       = A_ADD;
                end
            end
            S_EXEC: begin
                case (cls)
                    C_J, C_JAL: begin
                        pc_we  = 1'b1;
                        pc_src = 2'b10;
                    end
                    C_ILL: ;
                    default: begin
                        alu_src_a = 2'b10;
                        alu_src_b = b_sel;
                        op6       = exec_op;
                        if (cls == C_BR) begin
                            pc_cond_we = 1'b1;
                            pc_src     = 2'b01;
                        end
                        if (cls == C_JR || cls == C_JALR) begin
                            pc_we  = 1'b1;
                            pc_src = 2'b01;
                        end
                    end
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                lorD    = 2'b10;
                op6     = A_ADD;
                mem_we  = (cls == C_SW);
            end
            S_WB: begin
                reg_we = 1'b1;
                case (cls)
                    C_LW:    begin reg_dst = 2'b00; mem_to_reg = 2'b01; end
                    C_RCALC: begin reg_dst = 2'b01; mem_to_reg = 2'b00; end
                    C_JALR:  begin reg_dst = 2'b01; mem_to_reg = 2'b10; end
                    C_JAL:   begin reg_dst = 2'b10; mem_to_reg = 2'b10; end
                    default: begin reg_dst = 2'b00; mem_to_reg = 2'b00; end
                endcase
            end
            default: ;
        endcase
    end

    assign phase      = state;
    assign halted     = (state == S_HALT);
    assign alu_op     = ALUOP_W'(op6);
    assign instr_done = (state != S_FETCH) && (state != S_HALT) && (next == S_FETCH);

endmodule

// File: tb/tb_cu_seq.sv
// tb_cu_seq: directed bench for cu_seq. Stimulus pushes per-cycle expected
// field values into a scoreboard queue; a monitor on the falling edge pops and
// compares them against the DUT outputs for the matching cycle.
module tb_cu_seq;

    localparam int ALUOP_W = 6;

    logic               clk = 1'b0;
    logic               reset;
    logic [5:0]         op;
    logic [5:0]         irfunc;
    logic [4:0]         regimm;
    logic               mem_ready;
    logic [4:0]         phase;
    logic               ir_we, pc_inc, pc_we, pc_cond_we, mem_req, mem_we;
    logic [1:0]         lorD;
    logic               reg_we;
    logic [1:0]         reg_dst, mem_to_reg, alu_src_a;
    logic [2:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         pc_src;
    logic               instr_done, halted;
`ifdef CU_TRAP_EN
    logic               illegal;
`endif

    cu_seq #(.ALUOP_W(ALUOP_W), .WAIT_MAX(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .op(op), .irfunc(irfunc), .regimm(regimm),
        .mem_ready(mem_ready), .phase(phase), .ir_we(ir_we), .pc_inc(pc_inc),
        .pc_we(pc_we), .pc_cond_we(pc_cond_we), .mem_req(mem_req), .mem_we(mem_we),
        .lorD(lorD), .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .instr_done(instr_done),
`ifdef CU_TRAP_EN
        .illegal(illegal),
`endif
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef enum int {
        F_PHASE, F_IR_WE, F_PC_INC, F_PC_WE, F_PC_COND_WE, F_MEM_REQ, F_MEM_WE,
        F_LORD, F_REG_WE, F_REG_DST, F_MEM_TO_REG, F_ALU_SRC_A, F_ALU_SRC_B,
        F_ALU_OP, F_PC_SRC, F_INSTR_DONE, F_HALTED, F_ILLEGAL
    } field_t;

    typedef struct {
        int     cyc;
        field_t fid;
        int     val;
        string  nm;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int get_field(input field_t f);
        case (f)
            F_PHASE:      return int'(phase);
            F_IR_WE:      return int'(ir_we);
            F_PC_INC:     return int'(pc_inc);
            F_PC_WE:      return int'(pc_we);
            F_PC_COND_WE: return int'(pc_cond_we);
            F_MEM_REQ:    return int'(mem_req);
            F_MEM_WE:     return int'(mem_we);
            F_LORD:       return int'(lorD);
            F_REG_WE:     return int'(reg_we);
            F_REG_DST:    return int'(reg_dst);
            F_MEM_TO_REG: return int'(mem_to_reg);
            F_ALU_SRC_A:  return int'(alu_src_a);
            F_ALU_SRC_B:  return int'(alu_src_b);
            F_ALU_OP:     return int'(alu_op);
            F_PC_SRC:     return int'(pc_src);
            F_INSTR_DONE: return int'(instr_done);
            F_HALTED:     return int'(halted);
`ifdef CU_TRAP_EN
            F_ILLEGAL:    return int'(illegal);
`endif
            default:      return -1;
        endcase
    endfunction

    task automatic check(input string nm, input int got, input int exp_v);
        n_vec++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", nm, got, exp_v, cyc);
        end
    endtask

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < cyc) check({e.nm, ".stale"}, e.cyc, cyc);
            else             check(e.nm, get_field(e.fid), e.val);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input field_t f, input int v, input string nm);
        exp_t e;
        e.cyc = cyc;
        e.fid = f;
        e.val = v;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; mem_ready = 1'b0; op = 6'h00; irfunc = 6'h00; regimm = 5'h00;
        tick();
        // Reset state: FETCH values only.
        ex(F_PHASE, 5'b00001, "rst.phase");
        ex(F_MEM_REQ, 1, "rst.mem_req");
        ex(F_LORD, 2'b01, "rst.lorD");
        ex(F_IR_WE, 0, "rst.ir_we");
        ex(F_REG_WE, 0, "rst.reg_we");
        ex(F_ALU_OP, 0, "rst.alu_op");
        ex(F_INSTR_DONE, 0, "rst.instr_done");
        ex(F_HALTED, 0, "rst.halted");
`ifdef CU_TRAP_EN
        ex(F_ILLEGAL, 0, "rst.illegal");
`endif
        tick();
        reset = 1'b0; mem_ready = 1'b1;

        // add: FETCH, DECODE, EXEC, WB.
        op = 6'h00; irfunc = 6'h20;
        ex(F_PHASE, 5'b00001, "add.f.phase"); ex(F_IR_WE, 1, "add.f.ir_we");
        tick();
        ex(F_PHASE, 5'b00010, "add.d.phase"); ex(F_PC_INC, 1, "add.d.pc_inc");
        ex(F_INSTR_DONE, 0, "add.d.instr_done");
        tick();
        ex(F_PHASE, 5'b00100, "add.e.phase"); ex(F_ALU_OP, 6'b000010, "add.e.alu_op");
        ex(F_ALU_SRC_A, 2'b10, "add.e.src_a"); ex(F_ALU_SRC_B, 3'b001, "add.e.src_b");
        ex(F_REG_WE, 0, "add.e.reg_we");
        tick();
        ex(F_PHASE, 5'b10000, "add.w.phase"); ex(F_REG_WE, 1, "add.w.reg_we");
        ex(F_REG_DST, 2'b01, "add.w.reg_dst"); ex(F_MEM_TO_REG, 2'b00, "add.w.m2r");
        ex(F_INSTR_DONE, 1, "add.w.instr_done");
        tick();

        // lw with three not-ready cycles in MEM: 8 cycles total.
        op = 6'h23;
        ex(F_PHASE, 5'b00001, "lw.f.phase");
        tick();
        ex(F_PHASE, 5'b00010, "lw.d.phase");
        tick();
        ex(F_PHASE, 5'b00100, "lw.e.phase"); ex(F_ALU_SRC_B, 3'b011, "lw.e.src_b");
        ex(F_ALU_OP, 6'b000010, "lw.e.alu_op");
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            ex(F_PHASE, 5'b01000, "lw.mstall.phase"); ex(F_MEM_REQ, 1, "lw.mstall.mem_req");
            ex(F_LORD, 2'b10, "lw.mstall.lorD"); ex(F_MEM_WE, 0, "lw.mstall.mem_we");
            ex(F_INSTR_DONE, 0, "lw.mstall.instr_done");
            tick();
        end
        mem_ready = 1'b1;
        ex(F_PHASE, 5'b01000, "lw.m4.phase"); ex(F_LORD, 2'b10, "lw.m4.lorD");
        ex(F_ALU_OP, 6'b000010, "lw.m4.alu_op");
        tick();
        ex(F_PHASE, 5'b10000, "lw.w.phase"); ex(F_MEM_TO_REG, 2'b01, "lw.w.m2r");
        ex(F_REG_DST, 2'b00, "lw.w.reg_dst"); ex(F_INSTR_DONE, 1, "lw.w.instr_done");
        tick();

        // bne: 3 cycles, branch target computed in DECODE.
        op = 6'h05;
        ex(F_PHASE, 5'b00001, "bne.f.phase");
        tick();
        ex(F_ALU_SRC_A, 2'b01, "bne.d.src_a"); ex(F_ALU_SRC_B, 3'b101, "bne.d.src_b");
        ex(F_ALU_OP, 6'b000010, "bne.d.alu_op");
        tick();
        ex(F_PHASE, 5'b00100, "bne.e.phase"); ex(F_PC_COND_WE, 1, "bne.e.pc_cond_we");
        ex(F_ALU_OP, 6'b100001, "bne.e.alu_op"); ex(F_ALU_SRC_B, 3'b001, "bne.e.src_b");
        ex(F_PC_SRC, 2'b01, "bne.e.pc_src"); ex(F_INSTR_DONE, 1, "bne.e.instr_done");
        tick();

        // bltz (regimm rt=0): 3 cycles.
        op = 6'h01; regimm = 5'h00;
        ex(F_PHASE, 5'b00001, "bltz.f.phase");
        tick();
        ex(F_PHASE, 5'b00010, "bltz.d.phase");
        tick();
        ex(F_PC_COND_WE, 1, "bltz.e.pc_cond_we"); ex(F_ALU_OP, 6'b100100, "bltz.e.alu_op");
        ex(F_ALU_SRC_B, 3'b010, "bltz.e.src_b"); ex(F_INSTR_DONE, 1, "bltz.e.instr_done");
        tick();

        // jal: 4 cycles, links to $31.
        op = 6'h03;
        ex(F_PHASE, 5'b00001, "jal.f.phase");
        tick();
        tick();
        ex(F_PC_WE, 1, "jal.e.pc_we"); ex(F_PC_SRC, 2'b10, "jal.e.pc_src");
        ex(F_INSTR_DONE, 0, "jal.e.instr_done");
        tick();
        ex(F_PHASE, 5'b10000, "jal.w.phase"); ex(F_REG_DST, 2'b10, "jal.w.reg_dst");
        ex(F_MEM_TO_REG, 2'b10, "jal.w.m2r"); ex(F_INSTR_DONE, 1, "jal.w.instr_done");
        tick();

        // jr: 3 cycles, PASS_A onto the PC.
        op = 6'h00; irfunc = 6'h08;
        ex(F_PHASE, 5'b00001, "jr.f.phase");
        tick();
        tick();
        ex(F_PC_WE, 1, "jr.e.pc_we"); ex(F_PC_SRC, 2'b01, "jr.e.pc_src");
        ex(F_ALU_OP, 6'b001010, "jr.e.alu_op"); ex(F_INSTR_DONE, 1, "jr.e.instr_done");
        tick();

        // ori: zero-extended immediate, result to rt.
        op = 6'h0D;
        ex(F_PHASE, 5'b00001, "ori.f.phase");
        tick();
        tick();
        ex(F_ALU_SRC_B, 3'b100, "ori.e.src_b"); ex(F_ALU_OP, 6'b010000, "ori.e.alu_op");
        tick();
        ex(F_REG_WE, 1, "ori.w.reg_we"); ex(F_REG_DST, 2'b00, "ori.w.reg_dst");
        tick();

        // sw: store strobe in MEM, done there.
        op = 6'h2B;
        ex(F_PHASE, 5'b00001, "sw.f.phase");
        tick();
        tick();
        tick();
        ex(F_PHASE, 5'b01000, "sw.m.phase"); ex(F_MEM_WE, 1, "sw.m.mem_we");
        ex(F_INSTR_DONE, 1, "sw.m.instr_done");
        tick();

        // Unknown opcode 0x3F.
        op = 6'h3F;
        ex(F_PHASE, 5'b00001, "ill.f.phase");
        tick();
        ex(F_PHASE, 5'b00010, "ill.d.phase"); ex(F_PC_INC, 1, "ill.d.pc_inc");
`ifdef CU_TRAP_EN
        ex(F_INSTR_DONE, 0, "ill.d.instr_done");
        tick();
        ex(F_PHASE, 5'b00000, "ill.h.phase"); ex(F_HALTED, 1, "ill.h.halted");
        ex(F_ILLEGAL, 1, "ill.h.illegal"); ex(F_MEM_REQ, 0, "ill.h.mem_req");
`else
        ex(F_INSTR_DONE, 1, "ill.d.instr_done");
        tick();
        ex(F_PHASE, 5'b00001, "ill.next.phase"); ex(F_HALTED, 0, "ill.next.halted");
`endif

        // Timeout: WAIT_MAX=4, memory never ready in FETCH.
        reset = 1'b1;
        tick();
        reset = 1'b0; mem_ready = 1'b0; op = 6'h00; irfunc = 6'h20;
`ifdef CU_TRAP_EN
        ex(F_ILLEGAL, 0, "to.illegal_clr");
`endif
        for (int i = 0; i < 5; i++) begin
            ex(F_PHASE, 5'b00001, "to.stall.phase"); ex(F_HALTED, 0, "to.stall.halted");
            ex(F_IR_WE, 0, "to.stall.ir_we");
            tick();
        end
        ex(F_PHASE, 5'b00000, "to.h.phase"); ex(F_HALTED, 1, "to.h.halted");
        ex(F_MEM_REQ, 0, "to.h.mem_req"); ex(F_LORD, 2'b00, "to.h.lorD");
        ex(F_PC_INC, 0, "to.h.pc_inc"); ex(F_INSTR_DONE, 0, "to.h.instr_done");
        tick();
        mem_ready = 1'b1;
        ex(F_HALTED, 1, "to.sticky.halted"); ex(F_IR_WE, 0, "to.sticky.ir_we");
        ex(F_PHASE, 5'b00000, "to.sticky.phase");
        tick();
        reset = 1'b1;
        tick();
        ex(F_PHASE, 5'b00001, "to.rst.phase"); ex(F_HALTED, 0, "to.rst.halted");
        ex(F_MEM_REQ, 1, "to.rst.mem_req");
        tick();
        reset = 1'b0;
        tick();
        tick();

        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d expectations left unchecked", sb.size());
            n_fail += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/cu_seq.md
Name: cu_seq

Overview:
- Parametrised successor to the multi-cycle MIPS control unit.
- Owns its phase sequencer instead of taking an external one-hot phase. Each instruction class runs only the phases it needs (3–5 cycles).
- Stalls FETCH and MEM on a memory ready handshake, with a bounded wait timeout.
- Sits between the instruction register and the multi-cycle datapath. Drives the same control strobes and mux selects as the previous generation.

Parameters:
- ALUOP_W, 6: width of alu_op. Codes are zero-extended when ALUOP_W > 6.
- WAIT_MAX, 15: maximum consecutive not-ready cycles tolerated in FETCH or MEM before halting. Legal range is 1..255.
- CNT_W, 8: width of the wait counter. Must satisfy WAIT_MAX < 2^CNT_W.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; single clock domain
- op  in  6  IR[31:26]; valid from DECODE onward
- irfunc  in  6  IR[5:0]
- regimm  in  5  IR[20:16]
- mem_ready  in  1  memory completes the current request this cycle
- phase  out  5  one-hot: bit0 FETCH, bit1 DECODE, bit2 EXEC, bit3 MEM, bit4 WB; 0 in HALT
- ir_we  out  1  load IR (FETCH && mem_ready)
- pc_inc  out  1  PC+4 write (DECODE)
- pc_we  out  1  unconditional PC write (jumps, EXEC)
- pc_cond_we  out  1  conditional PC write (branches, EXEC)
- mem_req  out  1  memory request (FETCH, or MEM for lw/sw)
- mem_we  out  1  store (MEM && sw)
- lorD  out  2  01 instruction address, 10 data address, 00 idle
- reg_we  out  1  register write (WB)
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  00 ALU, 01 MDR, 10 PC (link)
- alu_src_a  out  2  00 PC, 01 PC (branch target in DECODE), 10 rs
- alu_src_b  out  3  000 const 4, 001 rt, 010 zero, 011 sign-ext imm, 100 zero-ext imm, 101 imm<<2
- alu_op  out  ALUOP_W  operation code
- pc_src  out  2  00 ALU, 01 ALUout/rs, 10 jump target
- instr_done  out  1  one-cycle pulse in the last phase of each instruction
- halted  out  1  sticky until reset

Behaviour:
- Reset: state FETCH, wait counter 0, halted 0, illegal 0. All strobes are 0 except mem_req=1 and lorD=01, which are the FETCH values. phase=00001.
- FETCH:
  - mem_req=1, lorD=01.
  - On mem_ready: ir_we=1, go to DECODE.
  - Otherwise stay; the counter increments each not-ready cycle.
- DECODE: pc_inc=1. For branches, compute the target with alu_src_a=01, alu_src_b=101, alu_op=ADD. Always go to EXEC.
- EXEC, per class:
  - R-calc (add/and/or/xor/nor/slt): a=10, b=001 → WB.
  - I-calc (addiu sign-ext; andi/ori/xori zero-ext): a=10, b=011/100 → WB.
  - lw/sw: address = rs + sign-ext imm → MEM.
  - beq/bne: b=001. bgez/bgtz/blez/bltz: b=010. pc_cond_we=1, pc_src=01 → FETCH.
  - j/jal: pc_we=1, pc_src=10. jr/jalr: pc_we=1, pc_src=01, alu_op=PASS_A. j/jr → FETCH; jal/jalr → WB.
- MEM:
  - mem_req=1, lorD=10, alu_op=ADD. mem_we=1 for sw.
  - On mem_ready: lw → WB; sw → FETCH.
  - Otherwise stay.
- WB: reg_we=1.
  - lw: reg_dst=00, mem_to_reg=01.
  - I-calc: reg_dst=00, mem_to_reg=00.
  - R-calc: reg_dst=01, mem_to_reg=00.
  - jalr: reg_dst=01, mem_to_reg=10.
  - jal: reg_dst=10, mem_to_reg=10.
  - → FETCH.
- Cycle counts with mem_ready always 1:
  - branch, j, jr: 3
  - R-calc, I-calc, sw, jal, jalr: 4
  - lw: 5
  - Each not-ready cycle adds 1.
- alu_op codes (6-bit):
  - ADD 000010, BEQ 000110, BNE 100001
  - BGEZ 010100, BGTZ 100010, BLEZ 001100, BLTZ 100100
  - SLT 001001, AND 001000, OR 010000, XOR 010001, NOR 100000
  - PASS_A 001010
  - Default, and all strobes outside the listed phases: 0.
- instr_done is asserted in the cycle whose next state is FETCH.
- Wait counter:
  - Cleared on any mem_ready and on every state change.
  - If the counter equals WAIT_MAX and mem_ready is 0 → HALT. In HALT, halted=1, all strobes are 0, and phase=0 until reset.
- Unknown opcode or funct: DECODE → FETCH (acts as a 2-cycle NOP), with instr_done pulsed in DECODE.
- Reset in any state, including HALT or a MEM stall, wins: the next cycle is FETCH with reset values.
- Op inputs are sampled combinationally. The IR must be stable from DECODE until instr_done.

Optional Feature:
- Macro CU_TRAP_EN.
- When defined: an unknown instruction goes DECODE → HALT. The extra output illegal (1 bit) is set and held with halted until reset, and instr_done is not pulsed.
- When undefined: there is no illegal port, and unknown instructions behave as a 2-cycle NOP.

Test Plan:
- add (op=0x00, funct=0x20), mem_ready=1:
  - phase goes 00001, 00010, 00100, 10000.
  - alu_op=000010 in EXEC.
  - reg_we=1, reg_dst=01 in cycle 4; instr_done in cycle 4.
- lw (op=0x23), mem_ready low for 3 cycles in MEM:
  - MEM is held 4 cycles with mem_req=1 and lorD=10.
  - Total 8 cycles; WB has mem_to_reg=01.
- bne (op=0x05), then bltz (op=0x01, rt=0):
  - Each takes 3 cycles.
  - pc_cond_we=1 in EXEC with alu_op 100001 and then 100100.
  - alu_src_b=001 for bne, 010 for bltz.
- jal (op=0x03):
  - pc_we=1, pc_src=10 in EXEC.
  - WB has reg_dst=10, mem_to_reg=10; 4 cycles total.
- WAIT_MAX=4, mem_ready=0 in FETCH:
  - halted=1 after the 5th not-ready cycle; all strobes 0.
  - reset=1 for one cycle restores FETCH with halted=0.
- op=0x3F:
  - Without CU_TRAP_EN: 2-cycle NOP with instr_done.
  - With CU_TRAP_EN: illegal=1 and halted=1 from the cycle after DECODE.
